axi4_stream_pkt_rr_arbiter: RTL and testbench
=============================================

Name: axi4_stream_pkt_rr_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one 16-bit AXI4-Stream datapath, the 16b-to-64b gearbox input, between N_SRC video/packet sources.
- Grant is locked from first beat to tlast, so packets are never interleaved.
- The winning source index goes out on tdest so downstream frame-buffer logic can steer data per source.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- DATA_WIDTH, 16, tdata width per source; tkeep/tstrb width = DATA_WIDTH/8.
- SRC_W, $clog2(N_SRC), localparam; width of source index / pkt_o_tdest.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- src_tvalid_i  in  N_SRC  per-source tvalid
- src_tready_o  out  N_SRC  per-source tready
- src_tdata_i  in  N_SRC*DATA_WIDTH  per-source tdata, source k at [k*DATA_WIDTH +: DATA_WIDTH]
- src_tkeep_i  in  N_SRC*DATA_WIDTH/8  per-source tkeep
- src_tstrb_i  in  N_SRC*DATA_WIDTH/8  per-source tstrb
- src_tlast_i  in  N_SRC  per-source tlast
- src_tuser_i  in  N_SRC  per-source tuser (start of frame)
- pkt_o_tvalid  out  1  merged tvalid
- pkt_o_tready  in  1  downstream ready
- pkt_o_tdata  out  DATA_WIDTH  merged tdata
- pkt_o_tkeep / pkt_o_tstrb  out  DATA_WIDTH/8  merged keep/strb
- pkt_o_tlast  out  1  merged tlast
- pkt_o_tuser  out  1  merged tuser
- pkt_o_tdest  out  SRC_W  index of granted source
- busy_o  out  1  high while a packet is locked

Behaviour:
- Reset (async, rst_i high): state=IDLE, grant=0, rr_ptr=N_SRC-1, pkt_o_tvalid=0, src_tready_o=0, busy_o=0; all other outputs 0.
- States: IDLE, BUSY.
- IDLE:
  - src_tready_o=0 and pkt_o_tvalid=0.
  - If any src_tvalid_i is high, register grant = first asserted index scanning rr_ptr+1, rr_ptr+2, ... modulo N_SRC, then go to BUSY.
  - Arbitration costs exactly one cycle.
- BUSY:
  - Zero-latency combinational pass-through of the granted source:
    - pkt_o_tvalid = src_tvalid_i[grant].
    - src_tready_o[grant] = pkt_o_tready; every other src_tready_o bit is 0.
    - data/keep/strb/last/user come from the granted slice.
    - pkt_o_tdest = grant.
  - busy_o=1.
- End of packet: on a handshake (pkt_o_tvalid && pkt_o_tready) with tlast=1, set rr_ptr <= grant and return to IDLE next cycle.
- Minimum gap: one idle cycle between packets.
- Fairness: a source that just finished has the lowest priority next round. With all N_SRC requesting, grant order is 0,1,...,N_SRC-1,0.
- Granted source drops tvalid mid-packet: the grant is held indefinitely; there is no timeout. pkt_o_tvalid follows the source low.
- Downstream backpressure: pkt_o_tready low stalls only the granted source. Data stays stable per AXI rules because it is passed straight through.
- Single-beat packet (tlast on first beat): BUSY lasts one cycle if pkt_o_tready=1.
- Non-granted sources asserting tvalid in BUSY are ignored. They keep their request and are served in priority order afterwards.
- Reset mid-packet: state returns to IDLE immediately and the packet is truncated. Sources must also be reset.
- No combinational path from src_tvalid_i to pkt_o_tvalid in IDLE; the grant is registered.

Optional Feature:
- Macro: PKT_ARB_STATS_EN.
- When defined:
  - Adds output stat_pkt_cnt_o, N_SRC*16 bits: one 16-bit counter per source.
  - A counter increments on each tlast handshake of that source and wraps from 0xFFFF to 0.
  - Adds input stat_clr_i, 1 bit: synchronous clear of all counters.
  - If clear and increment coincide, clear wins and the counter holds 0.
  - Counters reset to 0.
- When undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: all src_tvalid_i=0 for 10 cycles -> pkt_o_tvalid=0, src_tready_o=0, busy_o=0 throughout.
- Single source: src 2 sends a 4-beat packet (data 0x1111..0x4444, tuser on beat 0), pkt_o_tready=1:
  - Beats appear on pkt_o one cycle after request, contiguous.
  - tdest=2, tuser only on beat 0.
  - busy_o drops after the 4th beat.
- Round robin: all 4 sources continuously request 2-beat packets -> grant sequence 0,1,2,3,0,1; exactly one idle cycle between packets.
- Backpressure: src 1 granted, pkt_o_tready toggles 1,0,0,1 -> src_tready_o[1] mirrors pkt_o_tready, pkt_o_tdata holds stable while stalled, and other sources' src_tready_o stays 0.
- Lock under contention: src 0 sends 3 beats with a tvalid gap of 5 cycles mid-packet while src 3 requests -> src 3 is not granted until src 0's tlast handshake; its packet then starts 1 cycle later.
- With PKT_ARB_STATS_EN:
  - Src 1 completes 3 packets -> counter 1 reads 3, others 0.
  - Assert stat_clr_i on the same cycle as a tlast handshake -> all counters read 0.

Source files
------------

// File: rtl/axi4_stream_pkt_rr_arbiter.sv
// rtl/axi4_stream_pkt_rr_arbiter.sv - packet-atomic round-robin AXI4-Stream arbiter; optional per-source packet counters under PKT_ARB_STATS_EN
module axi4_stream_pkt_rr_arbiter #(
    parameter int  N_SRC      = 4,
    parameter int  DATA_WIDTH = 16,
    localparam int SRC_W      = $clog2(N_SRC),
    localparam int KEEP_W     = DATA_WIDTH / 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_SRC-1:0]            src_tvalid_i,
    output logic [N_SRC-1:0]            src_tready_o,
    input  logic [N_SRC*DATA_WIDTH-1:0] src_tdata_i,
    input  logic [N_SRC*KEEP_W-1:0]     src_tkeep_i,
    input  logic [N_SRC*KEEP_W-1:0]     src_tstrb_i,
    input  logic [N_SRC-1:0]            src_tlast_i,
    input  logic [N_SRC-1:0]            src_tuser_i,
    output logic                        pkt_o_tvalid,
    input  logic                        pkt_o_tready,
    output logic [DATA_WIDTH-1:0]       pkt_o_tdata,
    output logic [KEEP_W-1:0]           pkt_o_tkeep,
    output logic [KEEP_W-1:0]           pkt_o_tstrb,
    output logic                        pkt_o_tlast,
    output logic                        pkt_o_tuser,
    output logic [SRC_W-1:0]            pkt_o_tdest,
`ifdef PKT_ARB_STATS_EN
    input  logic                        stat_clr_i,
    output logic [N_SRC*16-1:0]         stat_pkt_cnt_o,
`endif
    output logic                        busy_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] arb_grant;
    logic             any_req;
    logic             pkt_done;

    assign any_req  = |src_tvalid_i;
    assign pkt_done = pkt_o_tvalid & pkt_o_tready & pkt_o_tlast;
    assign busy_o   = (state == ST_BUSY);

    // Pick the first requester after rr_ptr; scanning backwards lets the nearest one win.
    always_comb begin
        arb_grant = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            if (src_tvalid_i[SRC_W'((int'(rr_ptr) + i) % N_SRC)]) begin
                arb_grant = SRC_W'((int'(rr_ptr) + i) % N_SRC);
            end
        end
    end

    // Grant FSM: one arbitration cycle in IDLE, then hold the grant until the tlast handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= SRC_W'(N_SRC - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant <= arb_grant;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (pkt_done) begin
                        rr_ptr <= grant;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pass the granted source straight through while locked; everything is quiet in IDLE.
    always_comb begin
        src_tready_o = '0;
        pkt_o_tvalid = 1'b0;
        pkt_o_tdata  = '0;
        pkt_o_tkeep  = '0;
        pkt_o_tstrb  = '0;
        pkt_o_tlast  = 1'b0;
        pkt_o_tuser  = 1'b0;
        pkt_o_tdest  = '0;
        if (state == ST_BUSY) begin
            pkt_o_tdest = grant;
            for (int k = 0; k < N_SRC; k++) begin
                if (grant == SRC_W'(k)) begin
                    pkt_o_tvalid    = src_tvalid_i[k];
                    src_tready_o[k] = pkt_o_tready;
                    pkt_o_tdata     = src_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                    pkt_o_tkeep     = src_tkeep_i[k*KEEP_W +: KEEP_W];
                    pkt_o_tstrb     = src_tstrb_i[k*KEEP_W +: KEEP_W];
                    pkt_o_tlast     = src_tlast_i[k];
                    pkt_o_tuser     = src_tuser_i[k];
                end
            end
        end
    end

`ifdef PKT_ARB_STATS_EN
    logic [15:0] pkt_cnt [N_SRC];

    // Count completed packets per source; a clear in the same cycle overrides the increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_SRC; k++) pkt_cnt[k] <= '0;
        end else if (stat_clr_i) begin
            for (int k = 0; k < N_SRC; k++) pkt_cnt[k] <= '0;
        end else if (pkt_done) begin
            pkt_cnt[grant] <= pkt_cnt[grant] + 16'd1;
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_stat_out
        assign stat_pkt_cnt_o[g*16 +: 16] = pkt_cnt[g];
    end
`endif

endmodule

// File: tb/tb_axi4_stream_pkt_rr_arbiter.sv
// tb/tb_axi4_stream_pkt_rr_arbiter.sv - directed table-driven bench for axi4_stream_pkt_rr_arbiter
module tb_axi4_stream_pkt_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_vld, s_rdy, s_last, s_user;
    logic [63:0] s_data;
    logic [7:0]  s_keep, s_strb;
    logic        o_vld, o_rdy, o_last, o_user, busy;
    logic [15:0] o_data;
    logic [1:0]  o_keep, o_strb, o_dest;
`ifdef PKT_ARB_STATS_EN
    logic        stat_clr;
    logic [63:0] stat_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4_stream_pkt_rr_arbiter #(.N_SRC(4), .DATA_WIDTH(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .src_tvalid_i (s_vld),
        .src_tready_o (s_rdy),
        .src_tdata_i  (s_data),
        .src_tkeep_i  (s_keep),
        .src_tstrb_i  (s_strb),
        .src_tlast_i  (s_last),
        .src_tuser_i  (s_user),
        .pkt_o_tvalid (o_vld),
        .pkt_o_tready (o_rdy),
        .pkt_o_tdata  (o_data),
        .pkt_o_tkeep  (o_keep),
        .pkt_o_tstrb  (o_strb),
        .pkt_o_tlast  (o_last),
        .pkt_o_tuser  (o_user),
        .pkt_o_tdest  (o_dest),
`ifdef PKT_ARB_STATS_EN
        .stat_clr_i     (stat_clr),
        .stat_pkt_cnt_o (stat_cnt),
`endif
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [3:0]  vld;
        logic [3:0]  last;
        logic        ordy;
        logic        e_vld;
        logic [15:0] e_data;
        logic        e_last;
        logic        e_user;
        logic [1:0]  e_dest;
        logic [3:0]  e_srdy;
        logic        e_busy;
        logic [1:0]  e_keep;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] vld, input logic [3:0] last, input logic ordy,
                       input logic e_vld, input logic [15:0] e_data, input logic e_last,
                       input logic e_user, input logic [1:0] e_dest, input logic [3:0] e_srdy,
                       input logic e_busy, input logic [1:0] e_keep);
        vec_t v;
        v = '{vld, last, ordy, e_vld, e_data, e_last, e_user, e_dest, e_srdy, e_busy, e_keep};
        vecs.push_back(v);
    endtask

    task automatic src(input int k, input logic v, input logic [15:0] d, input logic l, input logic u);
        s_vld[k]          = v;
        s_data[k*16 +: 16] = d;
        s_last[k]         = l;
        s_user[k]         = u;
    endtask

    // two-beat round-robin stimulus: source k shows 0xAk0b where b is its current beat
    function automatic logic [63:0] rr_data(input logic [3:0] last);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = {4'hA, 4'(k), 7'b0, last[k]};
        return r;
    endfunction

    initial begin
        s_vld = '0; s_last = '0; s_user = '0; s_data = '0;
        s_keep = 8'b00_11_10_01;
        s_strb = 8'b00_11_10_01;
        o_rdy = 1'b1;
`ifdef PKT_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vld",  0, 64'(o_vld),  64'd0);
        chk("rst_srdy", 0, 64'(s_rdy),  64'd0);
        chk("rst_busy", 0, 64'(busy),   64'd0);
        chk("rst_dest", 0, 64'(o_dest), 64'd0);
        chk("rst_data", 0, 64'(o_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("idle_vld",  i, 64'(o_vld), 64'd0);
            chk("idle_srdy", i, 64'(s_rdy), 64'd0);
            chk("idle_busy", i, 64'(busy),  64'd0);
        end

        // round robin, all four sources sending 2-beat packets: grants 0,1,2,3,0,1
        add(4'hF, 4'h0, 1, 0, 16'h0000, 0, 0, 2'd0, 4'h0, 0, 2'b00);
        add(4'hF, 4'h0, 1, 1, 16'hA000, 0, 1, 2'd0, 4'h1, 1, 2'b01);
        add(4'hF, 4'h1, 1, 1, 16'hA001, 1, 0, 2'd0, 4'h1, 1, 2'b01);
        add(4'hF, 4'h0, 1, 0, 16'h0000, 0, 0, 2'd0, 4'h0, 0, 2'b00);
        add(4'hF, 4'h0, 1, 1, 16'hA100, 0, 1, 2'd1, 4'h2, 1, 2'b10);
        add(4'hF, 4'h2, 1, 1, 16'hA101, 1, 0, 2'd1, 4'h2, 1, 2'b10);
        add(4'hF, 4'h0, 1, 0, 16'h0000, 0, 0, 2'd0, 4'h0, 0, 2'b00);
        add(4'hF, 4'h0, 1, 1, 16'hA200, 0, 1, 2'd2, 4'h4, 1, 2'b11);
        add(4'hF, 4'h4, 1, 1, 16'hA201, 1, 0, 2'd2, 4'h4, 1, 2'b11);
        add(4'hF, 4'h0, 1, 0, 16'h0000, 0, 0, 2'd0, 4'h0, 0, 2'b00);
        add(4'hF, 4'h0, 1, 1, 16'hA300, 0, 1, 2'd3, 4'h8, 1, 2'b00);
        add(4'hF, 4'h8, 1, 1, 16'hA301, 1, 0, 2'd3, 4'h8, 1, 2'b00);
        add(4'hF, 4'h0, 1, 0, 16'h0000, 0, 0, 2'd0, 4'h0, 0, 2'b00);
        add(4'hF, 4'h0, 1, 1, 16'hA000, 0, 1, 2'd0, 4'h1, 1, 2'b01);
        add(4'hF, 4'h1, 1, 1, 16'hA001, 1, 0, 2'd0, 4'h1, 1, 2'b01);
        add(4'hF, 4'h0, 1, 0, 16'h0000, 0, 0, 2'd0, 4'h0, 0, 2'b00);
        add(4'hF, 4'h0, 1, 1, 16'hA100, 0, 1, 2'd1, 4'h2, 1, 2'b10);
        add(4'hF, 4'h2, 1, 1, 16'hA101, 1, 0, 2'd1, 4'h2, 1, 2'b10);
        add(4'h0, 4'h0, 1, 0, 16'h0000, 0, 0, 2'd0, 4'h0, 0, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            s_vld  = vecs[i].vld;
            s_last = vecs[i].last;
            s_user = ~vecs[i].last;
            s_data = rr_data(vecs[i].last);
            o_rdy  = vecs[i].ordy;
            #1;
            chk("rr_vld",  i, 64'(o_vld),  64'(vecs[i].e_vld));
            chk("rr_data", i, 64'(o_data), 64'(vecs[i].e_data));
            chk("rr_last", i, 64'(o_last), 64'(vecs[i].e_last));
            chk("rr_user", i, 64'(o_user), 64'(vecs[i].e_user));
            chk("rr_dest", i, 64'(o_dest), 64'(vecs[i].e_dest));
            chk("rr_srdy", i, 64'(s_rdy),  64'(vecs[i].e_srdy));
            chk("rr_busy", i, 64'(busy),   64'(vecs[i].e_busy));
            chk("rr_keep", i, 64'(o_keep), 64'(vecs[i].e_keep));
            chk("rr_strb", i, 64'(o_strb), 64'(vecs[i].e_keep));
        end
        s_user = '0; s_last = '0; s_data = '0;

        // single source 2 sends a 4-beat packet
        @(negedge clk);
        src(2, 1'b1, 16'h1111, 1'b0, 1'b1);
        #1;
        chk("ss_arb_vld",  0, 64'(o_vld), 64'd0);
        chk("ss_arb_busy", 0, 64'(busy),  64'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            src(2, 1'b1, 16'(16'h1111 * (b + 1)), 1'(b == 3), 1'(b == 0));
            #1;
            chk("ss_vld",  b, 64'(o_vld),  64'd1);
            chk("ss_data", b, 64'(o_data), 64'(16'h1111 * (b + 1)));
            chk("ss_dest", b, 64'(o_dest), 64'd2);
            chk("ss_user", b, 64'(o_user), 64'(b == 0));
            chk("ss_last", b, 64'(o_last), 64'(b == 3));
            chk("ss_busy", b, 64'(busy),   64'd1);
        end
        @(negedge clk);
        src(2, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("ss_end_busy", 0, 64'(busy), 64'd0);

        // backpressure on source 1, others join while it is locked
        @(negedge clk);
        src(1, 1'b1, 16'hB001, 1'b0, 1'b1);
        o_rdy = 1'b1;
        #1;
        chk("bp_arb_vld", 0, 64'(o_vld), 64'd0);
        @(negedge clk);
        src(0, 1'b1, 16'hC000, 1'b0, 1'b1);
        src(3, 1'b1, 16'hD000, 1'b1, 1'b1);
        #1;
        chk("bp_srdy", 0, 64'(s_rdy),  64'h2);
        chk("bp_data", 0, 64'(o_data), 64'hB001);
        @(negedge clk);
        src(1, 1'b1, 16'hB002, 1'b1, 1'b0);
        o_rdy = 1'b0;
        #1;
        chk("bp_srdy", 1, 64'(s_rdy),  64'h0);
        chk("bp_vld",  1, 64'(o_vld),  64'd1);
        chk("bp_data", 1, 64'(o_data), 64'hB002);
        @(negedge clk);
        #1;
        chk("bp_srdy", 2, 64'(s_rdy),  64'h0);
        chk("bp_data", 2, 64'(o_data), 64'hB002);
        chk("bp_dest", 2, 64'(o_dest), 64'd1);
        @(negedge clk);
        o_rdy = 1'b1;
        #1;
        chk("bp_srdy", 3, 64'(s_rdy),  64'h2);
        chk("bp_data", 3, 64'(o_data), 64'hB002);
        chk("bp_last", 3, 64'(o_last), 64'd1);
        @(negedge clk);
        src(1, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("bp_gap_busy", 0, 64'(busy),  64'd0);
        chk("bp_gap_vld",  0, 64'(o_vld), 64'd0);
        // rr_ptr=1: source 3 is next ahead of source 0; single-beat packet
        @(negedge clk);
        #1;
        chk("sb_dest", 0, 64'(o_dest), 64'd3);
        chk("sb_data", 0, 64'(o_data), 64'hD000);
        chk("sb_srdy", 0, 64'(s_rdy),  64'h8);
        chk("sb_last", 0, 64'(o_last), 64'd1);
        @(negedge clk);
        src(3, 1'b1, 16'hD001, 1'b1, 1'b1);
        #1;
        chk("sb_busy_drop", 0, 64'(busy), 64'd0);

        // lock under contention: source 0 stalls 5 cycles mid-packet while source 3 waits
        @(negedge clk);
        #1;
        chk("lk_dest", 0, 64'(o_dest), 64'd0);
        chk("lk_data", 0, 64'(o_data), 64'hC000);
        chk("lk_srdy", 0, 64'(s_rdy),  64'h1);
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            src(0, 1'b0, 16'hC001, 1'b0, 1'b0);
            #1;
            chk("lk_gap_vld",  g, 64'(o_vld),  64'd0);
            chk("lk_gap_busy", g, 64'(busy),   64'd1);
            chk("lk_gap_dest", g, 64'(o_dest), 64'd0);
            chk("lk_gap_srdy", g, 64'(s_rdy),  64'h1);
        end
        @(negedge clk);
        src(0, 1'b1, 16'hC001, 1'b0, 1'b0);
        #1;
        chk("lk_data", 1, 64'(o_data), 64'hC001);
        chk("lk_dest", 1, 64'(o_dest), 64'd0);
        @(negedge clk);
        src(0, 1'b1, 16'hC002, 1'b1, 1'b0);
        #1;
        chk("lk_last", 2, 64'(o_last), 64'd1);
        chk("lk_dest", 2, 64'(o_dest), 64'd0);
        @(negedge clk);
        src(0, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("lk_arb_busy", 0, 64'(busy),  64'd0);
        chk("lk_arb_srdy", 0, 64'(s_rdy), 64'h0);
        @(negedge clk);
        #1;
        chk("lk_next_dest", 0, 64'(o_dest), 64'd3);
        chk("lk_next_data", 0, 64'(o_data), 64'hD001);
        chk("lk_next_vld",  0, 64'(o_vld),  64'd1);
        @(negedge clk);
        src(3, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("lk_end_busy", 0, 64'(busy), 64'd0);

`ifdef PKT_ARB_STATS_EN
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        chk("st_clr", 0, stat_cnt, 64'd0);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            src(1, 1'b1, 16'(16'hE000 + p), 1'b1, 1'b1);
            @(negedge clk);
            #1;
            chk("st_dest", p, 64'(o_dest), 64'd1);
            @(negedge clk);
            src(1, 1'b0, 16'h0, 1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("st_cnt", k, 64'(stat_cnt[k*16 +: 16]), (k == 1) ? 64'd3 : 64'd0);
        end
        @(negedge clk);
        src(1, 1'b1, 16'hE003, 1'b1, 1'b1);
        @(negedge clk);
        stat_clr = 1'b1;
        #1;
        chk("st_clr_dest", 0, 64'(o_dest), 64'd1);
        chk("st_clr_hs",   0, 64'(o_vld & o_rdy & o_last), 64'd1);
        @(negedge clk);
        stat_clr = 1'b0;
        src(1, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("st_clr_win", 0, stat_cnt, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
